// File: rtl/axi_lite_arbiter_if.sv
// rtl/axi_lite_arbiter_if.sv - AXI4-Lite bundle shared by the arbiter and its neighbours
// Purpose: carries the five AXI4-Lite channels (aw, w, b, ar, r).
// Ports (modports):
//   master - drives aw/w/ar payload and valid, bready, rready
//   slave  - drives awready, wready, arready, b and r payload and valid
interface axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_arbiter.sv
// rtl/axi_lite_arbiter.sv - two-master AXI4-Lite arbiter onto one downstream slave
// Purpose: grants one transaction (read or write) at a time to m0 (IFU) or m1 (LSU).
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   m0    - requester 0 (axi_if.slave)
//   m1    - requester 1 (axi_if.slave)
//   s     - shared downstream path (axi_if.master)
// FIXED_PRIO: 0 = round-robin on ties, 1 = m1 always wins ties.
module axi_lite_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic  clk,
    input logic  reset,
    axi_if.slave  m0,
    axi_if.slave  m1,
    axi_if.master s
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t state_q;
    logic   gnt_q;
    logic   last_q;
    logic   ar_done_q;
    logic   aw_done_q;
    logic   w_done_q;

    logic in_rd, in_wr;
    logic req0, req1, win, win_rd;
    logic g_arvalid, g_awvalid, g_wvalid, g_rready, g_bready;
    logic ar_hs, aw_hs, w_hs, r_hs, b_hs;
    logic rd0, rd1, wr0, wr1;

    assign in_rd = (state_q == RD);
    assign in_wr = (state_q == WR);

    assign req0 = m0.arvalid | m0.awvalid | m0.wvalid;
    assign req1 = m1.arvalid | m1.awvalid | m1.wvalid;

    // On a tie the master not served last wins, unless m1 has fixed priority.
    assign win    = (req0 & req1) ? (FIXED_PRIO ? 1'b1 : ~last_q) : req1;
    assign win_rd = win ? m1.arvalid : m0.arvalid;

    assign g_arvalid = gnt_q ? m1.arvalid : m0.arvalid;
    assign g_awvalid = gnt_q ? m1.awvalid : m0.awvalid;
    assign g_wvalid  = gnt_q ? m1.wvalid  : m0.wvalid;
    assign g_rready  = gnt_q ? m1.rready  : m0.rready;
    assign g_bready  = gnt_q ? m1.bready  : m0.bready;

    // Completed address/data channels are masked so a held valid is not re-issued.
    assign s.arvalid = in_rd & ~ar_done_q & g_arvalid;
    assign s.araddr  = in_rd ? (gnt_q ? m1.araddr : m0.araddr) : '0;
    assign s.arprot  = in_rd ? (gnt_q ? m1.arprot : m0.arprot) : '0;
    assign s.rready  = in_rd & g_rready;

    assign s.awvalid = in_wr & ~aw_done_q & g_awvalid;
    assign s.awaddr  = in_wr ? (gnt_q ? m1.awaddr : m0.awaddr) : '0;
    assign s.awprot  = in_wr ? (gnt_q ? m1.awprot : m0.awprot) : '0;
    assign s.wvalid  = in_wr & ~w_done_q & g_wvalid;
    assign s.wdata   = in_wr ? (gnt_q ? m1.wdata : m0.wdata) : '0;
    assign s.wstrb   = in_wr ? (gnt_q ? m1.wstrb : m0.wstrb) : '0;
    assign s.bready  = in_wr & g_bready;

    assign ar_hs = in_rd & ~ar_done_q & g_arvalid & s.arready;
    assign aw_hs = in_wr & ~aw_done_q & g_awvalid & s.awready;
    assign w_hs  = in_wr & ~w_done_q & g_wvalid & s.wready;
    assign r_hs  = in_rd & s.rvalid & g_rready;
    assign b_hs  = in_wr & s.bvalid & g_bready;

    assign rd0 = in_rd & ~gnt_q;
    assign rd1 = in_rd & gnt_q;
    assign wr0 = in_wr & ~gnt_q;
    assign wr1 = in_wr & gnt_q;

    assign m0.arready = rd0 & ~ar_done_q & s.arready;
    assign m0.rvalid  = rd0 & s.rvalid;
    assign m0.rdata   = rd0 ? s.rdata : '0;
    assign m0.rresp   = rd0 ? s.rresp : '0;
    assign m0.awready = wr0 & ~aw_done_q & s.awready;
    assign m0.wready  = wr0 & ~w_done_q & s.wready;
    assign m0.bvalid  = wr0 & s.bvalid;
    assign m0.bresp   = wr0 ? s.bresp : '0;

    assign m1.arready = rd1 & ~ar_done_q & s.arready;
    assign m1.rvalid  = rd1 & s.rvalid;
    assign m1.rdata   = rd1 ? s.rdata : '0;
    assign m1.rresp   = rd1 ? s.rresp : '0;
    assign m1.awready = wr1 & ~aw_done_q & s.awready;
    assign m1.wready  = wr1 & ~w_done_q & s.wready;
    assign m1.bvalid  = wr1 & s.bvalid;
    assign m1.bresp   = wr1 ? s.bresp : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 | req1) begin
                        gnt_q     <= win;
                        last_q    <= win;
                        ar_done_q <= 1'b0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= win_rd ? RD : WR;
                    end
                end
                RD: begin
                    if (ar_hs) ar_done_q <= 1'b1;
                    if (r_hs)  state_q   <= IDLE;
                end
                WR: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                    if (b_hs)  state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb/tb_axi_lite_arbiter.sv - directed self-checking bench for axi_lite_arbiter
module tb_axi_lite_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    axi_if m0_if ();
    axi_if m1_if ();
    axi_if s_if ();
    axi_if m0b_if ();
    axi_if m1b_if ();
    axi_if sb_if ();

    axi_lite_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if), .s(s_if)
    );

    axi_lite_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .reset(reset), .m0(m0b_if), .m1(m1b_if), .s(sb_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        m0_if.awaddr = '0; m0_if.awprot = '0; m0_if.awvalid = 0; m0_if.wdata = '0;
        m0_if.wstrb = '0; m0_if.wvalid = 0; m0_if.bready = 0; m0_if.araddr = '0;
        m0_if.arprot = '0; m0_if.arvalid = 0; m0_if.rready = 0;
        m1_if.awaddr = '0; m1_if.awprot = '0; m1_if.awvalid = 0; m1_if.wdata = '0;
        m1_if.wstrb = '0; m1_if.wvalid = 0; m1_if.bready = 0; m1_if.araddr = '0;
        m1_if.arprot = '0; m1_if.arvalid = 0; m1_if.rready = 0;
        s_if.awready = 0; s_if.wready = 0; s_if.bresp = '0; s_if.bvalid = 0;
        s_if.arready = 0; s_if.rdata = '0; s_if.rresp = '0; s_if.rvalid = 0;
        m0b_if.awaddr = '0; m0b_if.awprot = '0; m0b_if.awvalid = 0; m0b_if.wdata = '0;
        m0b_if.wstrb = '0; m0b_if.wvalid = 0; m0b_if.bready = 0; m0b_if.araddr = '0;
        m0b_if.arprot = '0; m0b_if.arvalid = 0; m0b_if.rready = 0;
        m1b_if.awaddr = '0; m1b_if.awprot = '0; m1b_if.awvalid = 0; m1b_if.wdata = '0;
        m1b_if.wstrb = '0; m1b_if.wvalid = 0; m1b_if.bready = 0; m1b_if.araddr = '0;
        m1b_if.arprot = '0; m1b_if.arvalid = 0; m1b_if.rready = 0;
        sb_if.awready = 0; sb_if.wready = 0; sb_if.bresp = '0; sb_if.bvalid = 0;
        sb_if.arready = 0; sb_if.rdata = '0; sb_if.rresp = '0; sb_if.rvalid = 0;
    endtask

    task automatic do_reset();
        init_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Outputs must stay idle while reset is held, even with every request and response raised.
    task automatic test_reset();
        init_inputs();
        reset = 1'b1;
        m0_if.arvalid = 1; m0_if.araddr = 32'h1234;
        m1_if.awvalid = 1; m1_if.wvalid = 1; m1_if.rready = 1; m1_if.bready = 1;
        s_if.arready = 1; s_if.awready = 1; s_if.wready = 1; s_if.rvalid = 1; s_if.bvalid = 1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({s_if.arvalid, s_if.awvalid, s_if.wvalid, s_if.rready, s_if.bready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_s_valids: got %b exp 00000",
                     {s_if.arvalid, s_if.awvalid, s_if.wvalid, s_if.rready, s_if.bready});
        end
        checks++;
        if (s_if.araddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_araddr: got %h exp 00000000", s_if.araddr);
        end
        checks++;
        if ({m0_if.arready, m1_if.awready, m1_if.wready, m0_if.rvalid, m1_if.bvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_m_handshakes: got %b exp 00000",
                     {m0_if.arready, m1_if.awready, m1_if.wready, m0_if.rvalid, m1_if.bvalid});
        end
        tick();
        init_inputs();
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        m0_if.araddr = 32'h8000_0000; m0_if.arvalid = 1; m0_if.rready = 1;
        s_if.arready = 1;
        @(negedge clk);
        checks++;
        if (s_if.arvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_latency_c0: s.arvalid got %b exp 0", s_if.arvalid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (s_if.arvalid !== 1'b1 || s_if.araddr !== 32'h8000_0000 || m0_if.arready !== 1'b1) begin
            errors++;
            $display("FAIL rd_addr_c1: arvalid %b araddr %h arready %b exp 1 80000000 1",
                     s_if.arvalid, s_if.araddr, m0_if.arready);
        end
        tick();
        m0_if.arvalid = 0;
        s_if.rvalid = 1; s_if.rdata = 32'h0000_0013;
        @(negedge clk);
        checks++;
        if (m0_if.rvalid !== 1'b1 || m0_if.rdata !== 32'h0000_0013 || s_if.arvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_data: rvalid %b rdata %h arvalid %b exp 1 00000013 0",
                     m0_if.rvalid, m0_if.rdata, s_if.arvalid);
        end
        checks++;
        if ({m1_if.arready, m1_if.awready, m1_if.wready, m1_if.rvalid, m1_if.bvalid} !== 5'b0) begin
            errors++;
            $display("FAIL rd_m1_quiet: got %b exp 00000",
                     {m1_if.arready, m1_if.awready, m1_if.wready, m1_if.rvalid, m1_if.bvalid});
        end
        tick();
        s_if.rvalid = 0;
        @(negedge clk);
        checks++;
        if (s_if.rready !== 1'b0 || m0_if.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_back_idle: s.rready %b m0.rvalid %b exp 0 0", s_if.rready, m0_if.rvalid);
        end
    endtask

    task automatic test_tie_after_reset();
        do_reset();
        m0_if.araddr = 32'h1000; m0_if.arvalid = 1; m0_if.rready = 1;
        m1_if.awaddr = 32'h2000; m1_if.awvalid = 1;
        m1_if.wdata = 32'hdead_beef; m1_if.wstrb = 4'hf; m1_if.wvalid = 1; m1_if.bready = 1;
        s_if.arready = 1; s_if.awready = 1; s_if.wready = 1;
        tick();
        @(negedge clk);
        checks++;
        if (s_if.arvalid !== 1'b1 || s_if.araddr !== 32'h1000 || s_if.awvalid !== 1'b0) begin
            errors++;
            $display("FAIL tie_m0_first: arvalid %b araddr %h awvalid %b exp 1 00001000 0",
                     s_if.arvalid, s_if.araddr, s_if.awvalid);
        end
        checks++;
        if ({m1_if.awready, m1_if.wready} !== 2'b00) begin
            errors++;
            $display("FAIL tie_m1_held: awready/wready got %b exp 00", {m1_if.awready, m1_if.wready});
        end
        tick();
        m0_if.arvalid = 0;
        s_if.rvalid = 1; s_if.rdata = 32'h0000_cafe; s_if.rresp = 2'b10;
        @(negedge clk);
        checks++;
        if (m0_if.rresp !== 2'b10 || m0_if.rdata !== 32'h0000_cafe || m1_if.bvalid !== 1'b0) begin
            errors++;
            $display("FAIL tie_rresp: rresp %b rdata %h m1.bvalid %b exp 10 0000cafe 0",
                     m0_if.rresp, m0_if.rdata, m1_if.bvalid);
        end
        tick();
        s_if.rvalid = 0;
        @(negedge clk);
        checks++;
        if (s_if.awvalid !== 1'b0) begin
            errors++;
            $display("FAIL tie_idle_gap: s.awvalid got %b exp 0", s_if.awvalid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (s_if.awvalid !== 1'b1 || s_if.awaddr !== 32'h2000 || s_if.wvalid !== 1'b1 ||
            s_if.wdata !== 32'hdead_beef || m1_if.awready !== 1'b1) begin
            errors++;
            $display("FAIL tie_m1_write: awvalid %b awaddr %h wvalid %b wdata %h awready %b exp 1 00002000 1 deadbeef 1",
                     s_if.awvalid, s_if.awaddr, s_if.wvalid, s_if.wdata, m1_if.awready);
        end
        tick();
        m1_if.awvalid = 0; m1_if.wvalid = 0;
        s_if.bvalid = 1; s_if.bresp = 2'b11;
        @(negedge clk);
        checks++;
        if (m1_if.bvalid !== 1'b1 || m1_if.bresp !== 2'b11 || m0_if.bvalid !== 1'b0) begin
            errors++;
            $display("FAIL tie_bresp: m1.bvalid %b bresp %b m0.bvalid %b exp 1 11 0",
                     m1_if.bvalid, m1_if.bresp, m0_if.bvalid);
        end
        tick();
        s_if.bvalid = 0;
        m0_if.araddr = 32'h1004; m0_if.arvalid = 1;
        m1_if.araddr = 32'h2004; m1_if.arvalid = 1;
        tick();
        @(negedge clk);
        checks++;
        if (s_if.arvalid !== 1'b1 || s_if.araddr !== 32'h1004) begin
            errors++;
            $display("FAIL tie_second_m0: arvalid %b araddr %h exp 1 00001004", s_if.arvalid, s_if.araddr);
        end
    endtask

    task automatic test_w_before_aw();
        do_reset();
        m1_if.bready = 1;
        s_if.awready = 1; s_if.wready = 1; s_if.bresp = 2'b00;
        tick();
        m1_if.wdata = 32'h41; m1_if.wstrb = 4'h1; m1_if.wvalid = 1;
        @(negedge clk);
        checks++;
        if (s_if.wvalid !== 1'b0) begin
            errors++;
            $display("FAIL wfirst_idle: s.wvalid got %b exp 0", s_if.wvalid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (s_if.wvalid !== 1'b1 || s_if.wdata !== 32'h41 || s_if.awvalid !== 1'b0 || m1_if.wready !== 1'b1) begin
            errors++;
            $display("FAIL wfirst_w: wvalid %b wdata %h awvalid %b wready %b exp 1 00000041 0 1",
                     s_if.wvalid, s_if.wdata, s_if.awvalid, m1_if.wready);
        end
        tick();
        m1_if.awaddr = 32'ha000_03f8; m1_if.awvalid = 1;
        @(negedge clk);
        checks++;
        if (s_if.wvalid !== 1'b0 || m1_if.wready !== 1'b0) begin
            errors++;
            $display("FAIL wfirst_w_done: s.wvalid %b m1.wready %b exp 0 0", s_if.wvalid, m1_if.wready);
        end
        checks++;
        if (s_if.awvalid !== 1'b1 || s_if.awaddr !== 32'ha000_03f8 || m1_if.awready !== 1'b1) begin
            errors++;
            $display("FAIL wfirst_aw: awvalid %b awaddr %h awready %b exp 1 a00003f8 1",
                     s_if.awvalid, s_if.awaddr, m1_if.awready);
        end
        tick();
        m1_if.awvalid = 0; m1_if.wvalid = 0;
        s_if.bvalid = 1;
        @(negedge clk);
        checks++;
        if (s_if.awvalid !== 1'b0 || s_if.wvalid !== 1'b0 || m1_if.bvalid !== 1'b1 || m1_if.bresp !== 2'b00) begin
            errors++;
            $display("FAIL wfirst_b: awvalid %b wvalid %b bvalid %b bresp %b exp 0 0 1 00",
                     s_if.awvalid, s_if.wvalid, m1_if.bvalid, m1_if.bresp);
        end
        tick();
        s_if.bvalid = 0;
        @(negedge clk);
        checks++;
        if (s_if.bready !== 1'b0) begin
            errors++;
            $display("FAIL wfirst_back_idle: s.bready got %b exp 0", s_if.bready);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr;
        bit found;
        do_reset();
        m0_if.araddr = 32'h100; m0_if.arvalid = 1; m0_if.rready = 1;
        m1_if.araddr = 32'h200; m1_if.arvalid = 1; m1_if.rready = 1;
        s_if.arready = 1;
        for (int i = 0; i < 4; i++) begin
            exp_addr = (i % 2 == 0) ? 32'h100 : 32'h200;
            found = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (s_if.arvalid === 1'b1) begin
                    found = 1;
                    break;
                end
            end
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL rr_grant_%0d: no s.arvalid within 6 cycles", i);
            end else if (s_if.araddr !== exp_addr) begin
                errors++;
                $display("FAIL rr_grant_%0d: araddr got %h exp %h", i, s_if.araddr, exp_addr);
            end
            tick();
            s_if.rvalid = 1;
            tick();
            s_if.rvalid = 0;
        end
    endtask

    task automatic test_fixed_prio();
        logic [31:0] exp_addr;
        bit found;
        do_reset();
        m0b_if.araddr = 32'h100; m0b_if.arvalid = 1; m0b_if.rready = 1;
        m1b_if.araddr = 32'h200; m1b_if.arvalid = 1; m1b_if.rready = 1;
        sb_if.arready = 1;
        for (int i = 0; i < 4; i++) begin
            exp_addr = (i < 3) ? 32'h200 : 32'h100;
            found = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (sb_if.arvalid === 1'b1) begin
                    found = 1;
                    break;
                end
            end
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL fp_grant_%0d: no s.arvalid within 6 cycles", i);
            end else if (sb_if.araddr !== exp_addr ||
                         m0b_if.arready !== (exp_addr == 32'h100) ||
                         m1b_if.arready !== (exp_addr == 32'h200)) begin
                errors++;
                $display("FAIL fp_grant_%0d: araddr %h m0.arready %b m1.arready %b exp addr %h",
                         i, sb_if.araddr, m0b_if.arready, m1b_if.arready, exp_addr);
            end
            tick();
            sb_if.rvalid = 1;
            tick();
            sb_if.rvalid = 0;
            if (i == 2) m1b_if.arvalid = 0;
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        m1_if.awaddr = 32'h3000; m1_if.awvalid = 1; m1_if.bready = 1;
        s_if.awready = 1; s_if.wready = 0;
        tick();
        @(negedge clk);
        checks++;
        if (s_if.awvalid !== 1'b1 || s_if.awaddr !== 32'h3000) begin
            errors++;
            $display("FAIL rstwr_aw: awvalid %b awaddr %h exp 1 00003000", s_if.awvalid, s_if.awaddr);
        end
        tick();
        m1_if.awvalid = 0;
        m1_if.wdata = 32'h55; m1_if.wstrb = 4'hf; m1_if.wvalid = 1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (s_if.wvalid !== 1'b1 || s_if.awvalid !== 1'b0) begin
            errors++;
            $display("FAIL rstwr_w_pending: wvalid %b awvalid %b exp 1 0", s_if.wvalid, s_if.awvalid);
        end
        tick();
        s_if.wready = 1;
        @(negedge clk);
        checks++;
        if ({s_if.awvalid, s_if.wvalid, s_if.bready, m1_if.awready, m1_if.wready, m0_if.arready} !== 6'b0) begin
            errors++;
            $display("FAIL rstwr_idle: got %b exp 000000",
                     {s_if.awvalid, s_if.wvalid, s_if.bready, m1_if.awready, m1_if.wready, m0_if.arready});
        end
        tick();
        reset = 1'b0;
        m1_if.wvalid = 0;
        m0_if.araddr = 32'h8000_0000; m0_if.arvalid = 1; m0_if.rready = 1;
        s_if.arready = 1;
        tick();
        @(negedge clk);
        checks++;
        if (s_if.arvalid !== 1'b1 || s_if.araddr !== 32'h8000_0000 || m0_if.arready !== 1'b1) begin
            errors++;
            $display("FAIL rstwr_fresh_read: arvalid %b araddr %h arready %b exp 1 80000000 1",
                     s_if.arvalid, s_if.araddr, m0_if.arready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        init_inputs();
        test_reset();
        test_single_read();
        test_tie_after_reset();
        test_w_before_aw();
        test_round_robin();
        test_fixed_prio();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
